// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and the downstream pixel-bus type.
//   - XGA_*  : 1024x768 @ 60 Hz, 65 MHz pixel clock (generator defaults)
//   - SVGA_* : 800x600 @ 60 Hz, 40 MHz pixel clock (passed as overrides)
//   - vga_if_t: packed {hcount, hsync, hblnk, vcount, vsync, vblnk} bus
//     carried between the background, card and overlay stages.
package vga_pkg;

    localparam int VGA_CNT_W        = 11;

    localparam int XGA_H_ACTIVE     = 1024;
    localparam int XGA_H_TOTAL      = 1344;
    localparam int XGA_HSYNC_START  = 1048;
    localparam int XGA_HSYNC_STOP   = 1184;
    localparam int XGA_V_ACTIVE     = 768;
    localparam int XGA_V_TOTAL      = 806;
    localparam int XGA_VSYNC_START  = 771;
    localparam int XGA_VSYNC_STOP   = 777;

    localparam int SVGA_H_ACTIVE    = 800;
    localparam int SVGA_H_TOTAL     = 1056;
    localparam int SVGA_HSYNC_START = 840;
    localparam int SVGA_HSYNC_STOP  = 968;
    localparam int SVGA_V_ACTIVE    = 600;
    localparam int SVGA_V_TOTAL     = 628;
    localparam int SVGA_VSYNC_START = 601;
    localparam int SVGA_VSYNC_STOP  = 605;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] hcount;
        logic                 hsync;
        logic                 hblnk;
        logic [VGA_CNT_W-1:0] vcount;
        logic                 vsync;
        logic                 vblnk;
    } vga_if_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
//   clk, rst : pixel clock, synchronous active-high reset
//   step     : advance the counter this cycle
//   count    : registered position, 0..TOTAL-1
//   sync     : SYNC_POL while SYNC_START <= count < SYNC_STOP
//   blnk     : high while ACTIVE <= count < TOTAL
//   wrap     : count is at TOTAL-1 (the next step returns to 0)
// sync/blnk are decoded from the next count and registered, so they line
// up with count in the same cycle without an extra pipeline stage.
module vga_axis_counter #(
    parameter int   W          = 11,
    parameter int   TOTAL      = 1344,
    parameter int   ACTIVE     = 1024,
    parameter int   SYNC_START = 1048,
    parameter int   SYNC_STOP  = 1184,
    parameter logic SYNC_POL   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         sync,
    output logic         blnk,
    output logic         wrap
);

    logic [W-1:0] count_q, count_d;
    logic         sync_q, blnk_q;
    int           nxt;

    assign wrap = (int'(count_q) == TOTAL - 1);

    always_comb begin
        count_d = count_q;
        if (step) count_d = wrap ? '0 : count_q + 1'b1;
        // int compare keeps SYNC_STOP == 2**W from truncating to 0
        nxt = int'(count_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sync_q  <= ~SYNC_POL;
            blnk_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            blnk_q  <= (nxt >= ACTIVE);
            sync_q  <= (nxt >= SYNC_START && nxt < SYNC_STOP) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign count = count_q;
    assign sync  = sync_q;
    assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator (defaults 1024x768@60).
//   clk, rst      : pixel clock, synchronous active-high reset
//   en            : count enable; everything holds while low
//   hcount/vcount : pixel position
//   hsync/vsync   : sync at SYNC_POL level
//   hblnk/vblnk   : blanking, active-high
//   sof           : one-cycle pulse when (0,0) is presented
//   frame_cnt     : 16-bit frame counter, only with VGA_TIMING_FRAME_CNT_EN
// Optional build macro: VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CNT_W       = VGA_CNT_W,
    parameter int   H_ACTIVE    = XGA_H_ACTIVE,
    parameter int   H_TOTAL     = XGA_H_TOTAL,
    parameter int   HSYNC_START = XGA_HSYNC_START,
    parameter int   HSYNC_STOP  = XGA_HSYNC_STOP,
    parameter int   V_ACTIVE    = XGA_V_ACTIVE,
    parameter int   V_TOTAL     = XGA_V_TOTAL,
    parameter int   VSYNC_START = XGA_VSYNC_START,
    parameter int   VSYNC_STOP  = XGA_VSYNC_STOP,
    parameter logic SYNC_POL    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic             hsync,
    output logic             hblnk,
    output logic [CNT_W-1:0] vcount,
    output logic             vsync,
    output logic             vblnk,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             sof
);

    if (!(H_ACTIVE < HSYNC_START && HSYNC_START < HSYNC_STOP && HSYNC_STOP <= H_TOTAL))
    begin : g_bad_h
        $error("vga_timing_gen: illegal horizontal timing parameters");
    end
    if (!(V_ACTIVE < VSYNC_START && VSYNC_START < VSYNC_STOP && VSYNC_STOP <= V_TOTAL))
    begin : g_bad_v
        $error("vga_timing_gen: illegal vertical timing parameters");
    end
    if (!(CNT_W < 31 && H_TOTAL <= (1 << CNT_W) && V_TOTAL <= (1 << CNT_W)))
    begin : g_bad_w
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic h_wrap, v_wrap, frame_end;
    logic sof_q;

    vga_axis_counter #(
        .W(CNT_W), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(HSYNC_START), .SYNC_STOP(HSYNC_STOP), .SYNC_POL(SYNC_POL)
    ) u_h (
        .clk(clk), .rst(rst), .step(en),
        .count(hcount), .sync(hsync), .blnk(hblnk), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .W(CNT_W), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(VSYNC_START), .SYNC_STOP(VSYNC_STOP), .SYNC_POL(SYNC_POL)
    ) u_v (
        .clk(clk), .rst(rst), .step(en & h_wrap),
        .count(vcount), .sync(vsync), .blnk(vblnk), .wrap(v_wrap)
    );

    // Last pixel of the frame is being left: next cycle presents (0,0).
    assign frame_end = en & h_wrap & v_wrap;

    // Reset presents (0,0) as a fresh frame; afterwards only a real wrap
    // pulses, so a stalled (0,0) never re-fires.
    always_ff @(posedge clk) begin
        if (rst) sof_q <= 1'b1;
        else     sof_q <= frame_end;
    end
    assign sof = sof_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    // Counts wrap-generated frame starts only; the post-reset sof is excluded.
    always_ff @(posedge clk) begin
        if (rst)            frame_cnt_q <= '0;
        else if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Small mode so several full frames fit in the run.
    localparam int   CW  = 6;
    localparam int   HA  = 10, HSS = 12, HSE = 15, HT = 18;
    localparam int   VA  = 5,  VSS = 6,  VSE = 8,  VT = 9;
    localparam logic POL = 1'b0;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [CW-1:0] hcount, vcount;
    logic          hsync, hblnk, vsync, vblnk, sof;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: a linear pixel index within the frame.
    int mh, mv, mfc;
    bit msof;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(CW), .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_START(HSS), .HSYNC_STOP(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VSYNC_START(VSS), .VSYNC_STOP(VSE), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hcount(hcount), .hsync(hsync), .hblnk(hblnk),
        .vcount(vcount), .vsync(vsync), .vblnk(vblnk),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .sof(sof)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (h=%0d v=%0d)", tag, obs, exp, mh, mv);
        end
    endtask

    function automatic logic sync_of(input int c, input int s0, input int s1);
        return (c >= s0 && c < s1) ? POL : ~POL;
    endfunction

    // One clock: drive, advance the reference, then check everything.
    task automatic cyc(input bit r, input bit e);
        int p;
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            mh = 0; mv = 0; msof = 1; mfc = 0;
        end else if (e) begin
            p    = (mv * HT + mh + 1) % (HT * VT);
            mh   = p % HT;
            mv   = p / HT;
            msof = (p == 0);
            if (p == 0) mfc = (mfc + 1) % 65536;
        end else begin
            msof = 0;
        end
        #1;
        chk("hcount", 32'(hcount), 32'(mh));
        chk("vcount", 32'(vcount), 32'(mv));
        chk("hblnk",  32'(hblnk),  32'(mh >= HA));
        chk("vblnk",  32'(vblnk),  32'(mv >= VA));
        chk("hsync",  32'(hsync),  32'(sync_of(mh, HSS, HSE)));
        chk("vsync",  32'(vsync),  32'(sync_of(mv, VSS, VSE)));
        chk("sof",    32'(sof),    32'(msof));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(mfc));
`endif
    endtask

    initial begin
        int n_sof;
        rst = 1'b1;
        en  = 1'b0;
        mh = 0; mv = 0; mfc = 0; msof = 1;

        // Reset state, including rst winning over en.
        cyc(1, 0);
        cyc(1, 1);

        // Three full enabled frames; sof must pulse once per frame.
        n_sof = 0;
        for (int i = 0; i < 3 * HT * VT; i++) begin
            cyc(0, 1);
            if (sof === 1'b1) n_sof++;
        end
        chk("sof_per_3_frames", 32'(n_sof), 32'd3);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt_3", 32'(frame_cnt), 32'd3);
`endif

        // Stall mid-frame: outputs frozen, resume at the next pixel.
        for (int i = 0; i < HT * VT && !(mh == 4 && mv == 2); i++) cyc(0, 1);
        for (int i = 0; i < 7; i++) cyc(0, 0);
        cyc(0, 1);
        chk("resume_h", 32'(hcount), 32'd5);

        // Stall exactly on (0,0): no sof re-pulse.
        for (int i = 0; i < HT * VT && !(mh == 0 && mv == 0); i++) cyc(0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0);

        // Reset with both syncs active, then a full line to the next wrap.
        for (int i = 0; i < HT * VT && !(mh == 13 && mv == 6); i++) cyc(0, 1);
        chk("pre_rst_hsync", 32'(hsync), 32'(POL));
        cyc(1, 1);
        for (int i = 0; i < HT; i++) cyc(0, 1);
        chk("line_wrap_v", 32'(vcount), 32'd1);

        // Random enable with occasional reset.
        for (int i = 0; i < 1500; i++)
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
